// File: rtl/fc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fc_pkg
// Description : Shared widths, handshake state encodings and the token layout
//               for the FC1 elastic stage.
// Revision    : 1.0  initial clocked successor of the self-timed FC1 stage
// ============================================================================
package fc_pkg;

  localparam int c_def_node_w = 16;
  localparam int c_def_gen_w  = 12;
  localparam int c_def_data_w = 32;

  // Upstream (FC0-facing) 4-phase handshake states
  typedef enum logic [1:0] {
    IN_IDLE    = 2'd0,
    IN_ACK     = 2'd1,
    IN_RELEASE = 2'd2
  } in_state_t;

  // Downstream (SM-facing) 4-phase handshake states
  typedef enum logic [1:0] {
    OUT_EMPTY    = 2'd0,
    OUT_WAIT_DLY = 2'd1,
    OUT_SEND     = 2'd2,
    OUT_DRAIN    = 2'd3
  } out_state_t;

  // Token layout at the default widths, field order matches the output bus
  typedef struct packed {
    logic [c_def_node_w-1:0] node;
    logic [c_def_gen_w-1:0]  gen;
    logic [c_def_data_w-1:0] opr0;
    logic [c_def_data_w-1:0] opr1;
    logic [1:0]              mem_wen;
  } fc_token_t;

endpackage
`default_nettype wire

// File: rtl/fc_token_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fc_token_fifo
// Description : Small token FIFO with synchronous write/pop, full/empty,
//               occupancy, and combinational head and head+1 outputs.
//               Pointers carry one extra wrap bit to separate full from empty.
// Revision    : 1.0  initial
// ============================================================================
module fc_token_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_pop,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [WIDTH-1:0]         o_head,
  output logic [WIDTH-1:0]         o_head_next
);

  localparam int c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw:0]    r_wr_ptr;
  logic [c_aw:0]    r_rd_ptr;
  logic [c_aw-1:0]  w_rd_next;
  logic             w_do_wr;
  logic             w_do_pop;

  assign w_do_wr  = i_wr_en && !o_full;
  assign w_do_pop = i_pop && !o_empty;

  // Storage array; contents are don't-care until written so it has no reset
  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr[c_aw-1:0]] <= i_wr_data;
    end
  end

  // Read/write pointers advance independently so a write and pop may coincide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  assign o_count     = r_wr_ptr - r_rd_ptr;
  assign o_empty     = (r_wr_ptr == r_rd_ptr);
  assign o_full      = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                       (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign w_rd_next   = r_rd_ptr[c_aw-1:0] + 1'b1;
  assign o_head      = r_mem[r_rd_ptr[c_aw-1:0]];
  assign o_head_next = r_mem[w_rd_next];

endmodule
`default_nettype wire

// File: rtl/fc1_elastic_stage.sv
`default_nettype none
// ============================================================================
// Module      : fc1_elastic_stage
// Description : Clocked FC1 stage between FC0 (match lookup) and SM. Accepts
//               tokens over a 4-phase send/ack handshake, drops failed
//               matches, steers the operand pair by lr, buffers up to DEPTH
//               tokens and re-emits them over a 4-phase handshake after
//               SEND_DLY cycles.
//               Optional build macro FC1_STATS_EN adds saturating forward /
//               exclude counters (fwd_cnt_o, excl_cnt_o).
// Revision    : 1.0  initial
// ============================================================================
module fc1_elastic_stage
  import fc_pkg::*;
#(
  parameter int NODE_W   = c_def_node_w,
  parameter int GEN_W    = c_def_gen_w,
  parameter int DATA_W   = c_def_data_w,
  parameter int DEPTH    = 2,
  parameter int SEND_DLY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_send,
  output logic              in_ack,
  input  logic              lr_i,
  input  logic [NODE_W-1:0] node_i,
  input  logic [GEN_W-1:0]  gen_i,
  input  logic [DATA_W-1:0] opr_i,
  input  logic [1:0]        mem_wen_i,
  input  logic [DATA_W-1:0] mtch_data_i,
  input  logic              mtch_rslt_i,
  output logic              out_send,
  input  logic              out_ack,
  output logic [NODE_W-1:0] node_o,
  output logic [GEN_W-1:0]  gen_o,
  output logic [DATA_W-1:0] opr0_o,
  output logic [DATA_W-1:0] opr1_o,
  output logic [1:0]        mem_wen_o
`ifdef FC1_STATS_EN
  ,
  output logic [15:0]       fwd_cnt_o,
  output logic [15:0]       excl_cnt_o
`endif
);

  // Token at the configured widths; same field order as fc_token_t
  typedef struct packed {
    logic [NODE_W-1:0] node;
    logic [GEN_W-1:0]  gen;
    logic [DATA_W-1:0] opr0;
    logic [DATA_W-1:0] opr1;
    logic [1:0]        mem_wen;
  } tok_t;

  localparam int c_tok_w = $bits(tok_t);
  localparam int c_aw    = $clog2(DEPTH);
  // Counter only has to reach SEND_DLY-1; SEND_DLY of 0 and 1 both need
  // a single WAIT_DLY cycle, so they share the terminal value 0.
  localparam int c_cnt_w = (SEND_DLY > 1) ? $clog2(SEND_DLY) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last =
    (SEND_DLY > 1) ? c_cnt_w'(SEND_DLY - 1) : '0;
  localparam logic [c_aw:0] c_one = (c_aw + 1)'(1);

  in_state_t          r_in_state;
  out_state_t         r_out_state;
  logic [c_cnt_w-1:0] r_dly_cnt;

  logic               w_sample;
  logic               w_wr_en;
  logic               w_pop;
  logic               w_load;
  logic               w_full;
  logic               w_empty;
  logic [c_aw:0]      w_count;
  tok_t               w_wr_tok;
  tok_t               w_head;
  tok_t               w_head_next;
  tok_t               w_load_tok;

  // Inputs are taken only in IDLE with room in the FIFO; a full FIFO leaves
  // in_send pending without an acknowledge.
  assign w_sample = (r_in_state == IN_IDLE) && in_send && !w_full;
  assign w_wr_en  = w_sample && mtch_rslt_i;

  // Operand steering: lr selects which side the incoming operand occupies
  always_comb begin
    w_wr_tok.node    = node_i;
    w_wr_tok.gen     = gen_i;
    w_wr_tok.mem_wen = mem_wen_i;
    if (lr_i) begin
      w_wr_tok.opr0 = mtch_data_i;
      w_wr_tok.opr1 = opr_i;
    end else begin
      w_wr_tok.opr0 = opr_i;
      w_wr_tok.opr1 = mtch_data_i;
    end
  end

  fc_token_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (c_tok_w)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_wr_en     (w_wr_en),
    .i_wr_data   (w_wr_tok),
    .i_pop       (w_pop),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count),
    .o_head      (w_head),
    .o_head_next (w_head_next)
  );

  // Upstream handshake: ack rises after a sample, falls after in_send drops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_state <= IN_IDLE;
      in_ack     <= 1'b0;
    end else begin
      case (r_in_state)
        IN_IDLE: begin
          if (w_sample) begin
            r_in_state <= IN_ACK;
            in_ack     <= 1'b1;
          end
        end
        IN_ACK: begin
          if (!in_send) begin
            r_in_state <= IN_RELEASE;
            in_ack     <= 1'b0;
          end
        end
        IN_RELEASE: begin
          r_in_state <= IN_IDLE;
        end
        default: begin
          r_in_state <= IN_IDLE;
          in_ack     <= 1'b0;
        end
      endcase
    end
  end

  // Pop once the downstream has released its ack. The following entry is
  // loaded on that same edge only if it was already stored; an entry written
  // on the pop edge itself is picked up from EMPTY one cycle later.
  assign w_pop      = (r_out_state == OUT_DRAIN) && !out_ack;
  assign w_load     = ((r_out_state == OUT_EMPTY) && !w_empty) ||
                      (w_pop && (w_count > c_one));
  assign w_load_tok = (r_out_state == OUT_DRAIN) ? w_head_next : w_head;

  // Downstream handshake with programmable delay before out_send rises
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_state <= OUT_EMPTY;
      out_send    <= 1'b0;
      r_dly_cnt   <= '0;
    end else begin
      case (r_out_state)
        OUT_EMPTY: begin
          if (w_load) begin
            r_out_state <= OUT_WAIT_DLY;
            r_dly_cnt   <= '0;
          end
        end
        OUT_WAIT_DLY: begin
          if (r_dly_cnt == c_cnt_last) begin
            r_out_state <= OUT_SEND;
            out_send    <= 1'b1;
          end else begin
            r_dly_cnt <= r_dly_cnt + 1'b1;
          end
        end
        OUT_SEND: begin
          if (out_ack) begin
            r_out_state <= OUT_DRAIN;
            out_send    <= 1'b0;
          end
        end
        OUT_DRAIN: begin
          if (w_pop) begin
            r_dly_cnt   <= '0;
            r_out_state <= w_load ? OUT_WAIT_DLY : OUT_EMPTY;
          end
        end
        default: begin
          r_out_state <= OUT_EMPTY;
          out_send    <= 1'b0;
        end
      endcase
    end
  end

  // Output data register: holds the head from load until it is popped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      node_o    <= '0;
      gen_o     <= '0;
      opr0_o    <= '0;
      opr1_o    <= '0;
      mem_wen_o <= '0;
    end else if (w_load) begin
      node_o    <= w_load_tok.node;
      gen_o     <= w_load_tok.gen;
      opr0_o    <= w_load_tok.opr0;
      opr1_o    <= w_load_tok.opr1;
      mem_wen_o <= w_load_tok.mem_wen;
    end
  end

`ifdef FC1_STATS_EN
  // Saturating counters of forwarded (popped) and excluded (dropped) tokens
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_cnt_o  <= '0;
      excl_cnt_o <= '0;
    end else begin
      if (w_pop && (fwd_cnt_o != 16'hFFFF)) begin
        fwd_cnt_o <= fwd_cnt_o + 16'd1;
      end
      if (w_sample && !mtch_rslt_i && (excl_cnt_o != 16'hFFFF)) begin
        excl_cnt_o <= excl_cnt_o + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fc1_elastic_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fc1_elastic_stage
// Description : Scoreboard bench for fc1_elastic_stage (default parameters,
//               SEND_DLY=3, DEPTH=2). Directed tokens push hand-computed
//               expected outputs; a monitor pops and compares on each
//               out_send rise.
// Revision    : 1.0  initial
// ============================================================================
module tb_fc1_elastic_stage;
  import fc_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_send;
  logic        in_ack;
  logic        lr_i;
  logic [15:0] node_i;
  logic [11:0] gen_i;
  logic [31:0] opr_i;
  logic [1:0]  mem_wen_i;
  logic [31:0] mtch_data_i;
  logic        mtch_rslt_i;
  logic        out_send;
  logic        out_ack;
  logic [15:0] node_o;
  logic [11:0] gen_o;
  logic [31:0] opr0_o;
  logic [31:0] opr1_o;
  logic [1:0]  mem_wen_o;
`ifdef FC1_STATS_EN
  logic [15:0] fwd_cnt_o;
  logic [15:0] excl_cnt_o;
`endif

  fc1_elastic_stage dut (
    .clk         (clk),
    .rst         (rst),
    .in_send     (in_send),
    .in_ack      (in_ack),
    .lr_i        (lr_i),
    .node_i      (node_i),
    .gen_i       (gen_i),
    .opr_i       (opr_i),
    .mem_wen_i   (mem_wen_i),
    .mtch_data_i (mtch_data_i),
    .mtch_rslt_i (mtch_rslt_i),
    .out_send    (out_send),
    .out_ack     (out_ack),
    .node_o      (node_o),
    .gen_o       (gen_o),
    .opr0_o      (opr0_o),
    .opr1_o      (opr1_o),
    .mem_wen_o   (mem_wen_o)
`ifdef FC1_STATS_EN
    ,
    .fwd_cnt_o   (fwd_cnt_o),
    .excl_cnt_o  (excl_cnt_o)
`endif
  );

  int          total = 0;
  int          bad   = 0;
  fc_token_t   sb[$];
  logic        hold;
  logic        manual;
  logic        man_ack;
  logic        auto_ack;
  logic        prev_send;

  assign out_ack = manual ? man_ack : auto_ack;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every out_send rise must present the oldest expected token
  always @(negedge clk) begin
    fc_token_t e;
    if (out_send && !prev_send) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL tok_unexpected: got %0h expected none",
                 {node_o, gen_o, opr0_o, opr1_o, mem_wen_o});
      end else begin
        e = sb.pop_front();
        check("tok", 128'({node_o, gen_o, opr0_o, opr1_o, mem_wen_o}), 128'(e));
      end
    end
    prev_send = out_send;
  end

  // Downstream responder; 'hold' stalls the acknowledge
  always @(negedge clk) begin
    if (rst) auto_ack = 1'b0;
    else if (out_send && !hold) auto_ack = 1'b1;
    else if (!out_send) auto_ack = 1'b0;
  end

  task automatic drive(input logic lr, input logic [15:0] nd, input logic [11:0] gn,
                       input logic [31:0] op, input logic [31:0] md,
                       input logic [1:0] wen, input logic rs);
    lr_i = lr; node_i = nd; gen_i = gn; opr_i = op;
    mtch_data_i = md; mem_wen_i = wen; mtch_rslt_i = rs;
  endtask

  task automatic push_exp(input logic [15:0] nd, input logic [11:0] gn,
                          input logic [31:0] e0, input logic [31:0] e1,
                          input logic [1:0] wen);
    fc_token_t t;
    t.node = nd; t.gen = gn; t.opr0 = e0; t.opr1 = e1; t.mem_wen = wen;
    sb.push_back(t);
  endtask

  task automatic wait_ack(input logic lvl, input string nm);
    int n = 0;
    while (in_ack !== lvl && n < 100) begin @(posedge clk); #1; n++; end
    check(nm, 128'(in_ack), 128'(lvl));
  endtask

  task automatic wait_send(input logic lvl, input string nm);
    int n = 0;
    while (out_send !== lvl && n < 100) begin @(posedge clk); #1; n++; end
    check(nm, 128'(out_send), 128'(lvl));
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while ((sb.size() != 0 || out_send) && n < 300) begin @(posedge clk); #1; n++; end
    repeat (3) @(posedge clk);
    #1;
    check(nm, 128'(sb.size()), 128'(0));
  endtask

  // Full upstream 4-phase transfer of one token
  task automatic send_tok(input logic lr, input logic [15:0] nd, input logic [11:0] gn,
                          input logic [31:0] op, input logic [31:0] md,
                          input logic [1:0] wen, input logic rs,
                          input logic [31:0] e0, input logic [31:0] e1);
    @(posedge clk); #1;
    drive(lr, nd, gn, op, md, wen, rs);
    if (rs) push_exp(nd, gn, e0, e1, wen);
    in_send = 1'b1;
    wait_ack(1'b1, "ack_rise");
    in_send = 1'b0;
    wait_ack(1'b0, "ack_fall");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int hi_cnt;
    rst = 1'b1; in_send = 1'b0; hold = 1'b0; manual = 1'b0; man_ack = 1'b0;
    auto_ack = 1'b0; prev_send = 1'b0;
    drive(1'b0, 16'h0, 12'h0, 32'h0, 32'h0, 2'b00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", 128'({in_ack, out_send}), 128'(2'b00));
    check("rst_data", 128'({node_o, gen_o, opr0_o, opr1_o, mem_wen_o}), 128'(0));
    rst = 1'b0;

    // 1: lr=0, latency in_send rise -> out_send rise is 2+3 cycles
    lat = 0;
    fork
      send_tok(1'b0, 16'h0101, 12'h001, 32'h11, 32'h22, 2'b01, 1'b1, 32'h11, 32'h22);
      begin
        @(posedge in_send);
        while (!out_send && lat < 50) begin @(posedge clk); lat++; #1; end
      end
    join
    check("latency", 128'(lat), 128'(5));
    wait_drain("t1_drain");

    // 2: lr=1 swaps the operand pair, other fields pass through
    send_tok(1'b1, 16'h0A0B, 12'hABC, 32'h11, 32'h22, 2'b10, 1'b1, 32'h22, 32'h11);
    wait_drain("t2_drain");
`ifdef FC1_STATS_EN
    check("fwd_cnt", 128'(fwd_cnt_o), 128'(2));
`endif

    // 3: failed match completes the handshake but is never emitted
    send_tok(1'b0, 16'h0303, 12'h033, 32'h33, 32'h34, 2'b11, 1'b0, 32'h0, 32'h0);
    hi_cnt = 0;
    for (int i = 0; i < 20; i++) begin @(posedge clk); #1; if (out_send) hi_cnt++; end
    check("excl_quiet", 128'(hi_cnt), 128'(0));
`ifdef FC1_STATS_EN
    check("excl_cnt", 128'(excl_cnt_o), 128'(1));
`endif

    // 4: stalled downstream, third token waits for the first pop
    hold = 1'b1;
    send_tok(1'b0, 16'h0401, 12'h401, 32'hA0, 32'hA1, 2'b11, 1'b1, 32'hA0, 32'hA1);
    send_tok(1'b1, 16'h0402, 12'h402, 32'hB0, 32'hB1, 2'b01, 1'b1, 32'hB1, 32'hB0);
    @(posedge clk); #1;
    drive(1'b0, 16'h0403, 12'h403, 32'hC0, 32'hC1, 2'b10, 1'b1);
    push_exp(16'h0403, 12'h403, 32'hC0, 32'hC1, 2'b10);
    in_send = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("full_noack", 128'(in_ack), 128'(0));
    hold = 1'b0;
    wait_ack(1'b1, "full_ack_after_pop");
    in_send = 1'b0;
    wait_ack(1'b0, "full_ack_fall");
    wait_drain("t4_drain");

    // 5: write and pop on the same edge with one entry stored
    manual = 1'b1; man_ack = 1'b0;
    send_tok(1'b0, 16'h0501, 12'h501, 32'h50, 32'h51, 2'b01, 1'b1, 32'h50, 32'h51);
    wait_send(1'b1, "t5_send");
    man_ack = 1'b1;
    wait_send(1'b0, "t5_send_fall");
    drive(1'b1, 16'h0502, 12'h502, 32'h60, 32'h61, 2'b10, 1'b1);
    push_exp(16'h0502, 12'h502, 32'h61, 32'h60, 2'b10);
    in_send = 1'b1;
    man_ack = 1'b0;
    @(posedge clk); #1;
    check("wp_count", 128'(dut.u_fifo.o_count), 128'(1));
    check("wp_full", 128'(dut.u_fifo.o_full), 128'(0));
    check("wp_ack", 128'(in_ack), 128'(1));
    in_send = 1'b0;
    manual = 1'b0;
    wait_ack(1'b0, "wp_ack_fall");
    send_tok(1'b0, 16'h0503, 12'h503, 32'h70, 32'h71, 2'b11, 1'b1, 32'h70, 32'h71);
    wait_drain("t5_drain");

    // 6: async reset while out_send=1 and in_ack=1
    hold = 1'b1;
    send_tok(1'b0, 16'h0601, 12'h601, 32'h80, 32'h81, 2'b01, 1'b1, 32'h80, 32'h81);
    wait_send(1'b1, "t6_send");
    drive(1'b0, 16'h0602, 12'h602, 32'h85, 32'h86, 2'b01, 1'b1);
    in_send = 1'b1;
    wait_ack(1'b1, "t6_ack");
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("arst_ctrl", 128'({in_ack, out_send}), 128'(2'b00));
    check("arst_data", 128'({node_o, gen_o, opr0_o, opr1_o, mem_wen_o}), 128'(0));
    in_send = 1'b0;
    hold = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    send_tok(1'b1, 16'h0603, 12'h603, 32'h90, 32'h91, 2'b10, 1'b1, 32'h91, 32'h90);
    wait_drain("t6_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
